// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: shared constants, op encodings and FSM states for shift_sequencer.
// SHIFT_SEQ_ROR_EN enables the two-pass rotate-right op.
package shift_seq_pkg;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRA  = 2'b01;
    localparam logic [1:0] OP_ROR  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;
    typedef enum logic [1:0] {IDLE, EXEC1, EXEC2, RESP} seq_state_t;
    function automatic logic op_ok(input logic [1:0] op);
`ifdef SHIFT_SEQ_ROR_EN
        return op != OP_RSVD;
`else
        return op == OP_SLL || op == OP_SRA;
`endif
    endfunction
endpackage

// File: rtl/shift_sequencer_shifter.sv
// Shifter: combinational barrel shifter; Mode 0 shifts left logical, Mode 1 shifts right arithmetic.
module Shifter #(
    parameter int DW = 16,
    parameter int AW = 4
) (
    output logic [DW-1:0] Shift_Out,
    input  logic [DW-1:0] Shift_In,
    input  logic [AW-1:0] Shift_Val,
    input  logic          Mode
);
    assign Shift_Out = Mode ? DW'($signed(Shift_In) >>> Shift_Val) : Shift_In << Shift_Val;
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: valid/ready sequencer driving one Shifter for SLL, SRA and (with
// SHIFT_SEQ_ROR_EN) a two-pass rotate-right; other ops return an error response.
module shift_sequencer #(
    parameter int DW = shift_seq_pkg::DW,
    parameter int AW = shift_seq_pkg::AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [DW-1:0] req_data,
    input  logic [AW-1:0] req_amt,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic          busy
);
    import shift_seq_pkg::*;

    seq_state_t    state_q, state_d;
    logic          ready_q, ready_d, err_q, err_d, mode;
    logic [1:0]    op_q, op_d;
    logic [DW-1:0] data_q, data_d, acc_q, acc_d, sh_in, sh_out;
    logic [AW-1:0] amt_q, amt_d, sh_val;

    Shifter #(.DW(DW), .AW(AW)) u_shifter (
        .Shift_Out(sh_out),
        .Shift_In (sh_in),
        .Shift_Val(sh_val),
        .Mode     (mode)
    );

    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        op_d    = op_q;
        data_d  = data_q;
        amt_d   = amt_q;
        acc_d   = acc_q;
        err_d   = err_q;
        mode    = 1'b0;
        sh_in   = '0;
        sh_val  = '0;
        unique case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (req_valid && ready_q) begin
                    ready_d = 1'b0;
                    op_d    = req_op;
                    data_d  = req_data;
                    amt_d   = req_amt;
                    acc_d   = '0;
                    err_d   = !op_ok(req_op);
                    state_d = op_ok(req_op) ? EXEC1 : RESP;
                end
            end
            EXEC1: begin
                mode    = op_q != OP_SLL;
                sh_in   = data_q;
                sh_val  = amt_q;
                acc_d   = sh_out;
                state_d = RESP;
`ifdef SHIFT_SEQ_ROR_EN
                // First pass moves x[14:0] down; bit 15 is merged separately in EXEC2
                if (op_q == OP_ROR) begin
                    sh_in   = {1'b0, data_q[DW-2:0]};
                    acc_d   = amt_q == '0 ? data_q : sh_out;
                    state_d = amt_q == '0 ? RESP : EXEC2;
                end
`endif
            end
            EXEC2: begin
`ifdef SHIFT_SEQ_ROR_EN
                // (16-n) mod 16 equals -n in AW bits
                sh_in   = data_q;
                sh_val  = '0 - amt_q;
                acc_d   = acc_q | sh_out | (DW'(data_q[DW-1]) << (AW'(DW - 1) - amt_q));
                state_d = RESP;
`else
                state_d = IDLE;
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            op_q    <= OP_SLL;
            data_q  <= '0;
            amt_q   <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            op_q    <= op_d;
            data_q  <= data_d;
            amt_q   <= amt_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = state_q == RESP;
    assign rsp_data  = acc_q;
    assign rsp_err   = err_q;
    assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed plus randomized checks of shift_sequencer against an arithmetic model.
module tb_shift_sequencer;
    logic        clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, rsp_ready = 1'b0;
    logic [1:0]  req_op = '0;
    logic [15:0] req_data = '0;
    logic [3:0]  req_amt = '0;
    logic        req_ready, rsp_valid, rsp_err, busy;
    logic [15:0] rsp_data;
    int vectors = 0, errors = 0;

    shift_sequencer dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_data(req_data), .req_amt(req_amt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] model(input logic [1:0] op, input logic [15:0] x, input int n);
        logic [31:0] w;
        w = {16'h0, x};
        if (op == 2'b00) return {1'b0, 16'((w << n) & 32'hFFFF)};
        if (op == 2'b01) return {1'b0, 16'(($signed({{16{x[15]}}, x}) >>> n) & 32'hFFFF)};
`ifdef SHIFT_SEQ_ROR_EN
        if (op == 2'b10) return {1'b0, 16'(((w >> n) | (w << (16 - n))) & 32'hFFFF)};
`endif
        return 17'h10000;
    endfunction

    function automatic int lat_of(input logic [1:0] op, input int n);
        if (model(op, 16'h0, 0) == 17'h10000) return 1;
        return (op == 2'b10 && n != 0) ? 3 : 2;
    endfunction

    task automatic send(input logic [1:0] op, input logic [15:0] d, input logic [3:0] a);
        int w = 0;
        @(negedge clk);
        while (!req_ready && w < 20) begin @(negedge clk); w++; end
        chk("ready_before_send", req_ready, 1);
        req_valid = 1'b1; req_op = op; req_data = d; req_amt = a;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("ready_drop", req_ready, 0);
        chk("busy", busy, 1);
    endtask

    task automatic await_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 10) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic run(input logic [1:0] op, input logic [15:0] d, input logic [3:0] a,
                       input int hold, input bit pre);
        int lat;
        logic [16:0] exp;
        exp = model(op, d, int'(a));
        rsp_ready = pre;
        send(op, d, a);
        await_rsp(lat);
        chk("latency", lat, lat_of(op, int'(a)));
        chk("rsp_data", rsp_data, exp[15:0]);
        chk("rsp_err", rsp_err, exp[16]);
        repeat (pre ? 0 : hold) begin
            @(posedge clk); #1;
            chk("hold_data", {rsp_valid, rsp_err, rsp_data}, {1'b1, exp});
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("valid_drop", rsp_valid, 0);
        chk("ready_back", req_ready, 1);
    endtask

    initial begin
        int lat;
        #2;
        chk("reset_outs", {req_ready, rsp_valid, rsp_data, rsp_err, busy}, 0);
        @(negedge clk); rst_n = 1'b1;
        #1 chk("ready_pre_edge", req_ready, 0);
        @(posedge clk); #1;
        chk("ready_after_reset", req_ready, 1);
        run(2'b01, 16'hF007, 4'd2, 0, 1'b1);
        run(2'b00, 16'hF007, 4'd2, 1, 1'b0);
        run(2'b01, 16'h0007, 4'd6, 0, 1'b0);
        run(2'b10, 16'h1234, 4'd4, 0, 1'b0);
        run(2'b10, 16'h8001, 4'd1, 2, 1'b0);
        run(2'b10, 16'hABCD, 4'd0, 0, 1'b1);
        run(2'b11, 16'h5A5A, 4'd7, 1, 1'b0);
        run(2'b00, 16'h0001, 4'd15, 0, 1'b0);
        // backpressure with a second request pending
        send(2'b00, 16'hF007, 4'd2);
        await_rsp(lat);
        req_valid = 1'b1; req_op = 2'b01; req_data = 16'h0007; req_amt = 4'd6;
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_data", {rsp_valid, rsp_err, rsp_data}, {2'b10, 16'hC01C});
            chk("bp_ready_low", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("bp_ready_back", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("second_accepted", {busy, req_ready}, 2'b10);
        await_rsp(lat);
        chk("second_lat", lat, 2);
        chk("second_data", rsp_data, 16'h0000);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        // reset in the middle of an operation (EXEC2 when rotate is built in)
`ifdef SHIFT_SEQ_ROR_EN
        send(2'b10, 16'h1234, 4'd4);
        @(posedge clk); #1;
`else
        send(2'b00, 16'h1234, 4'd4);
`endif
        rst_n = 1'b0;
        #1 chk("midreset_outs", {req_ready, rsp_valid, rsp_data, rsp_err, busy}, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midreset_ready", {req_ready, rsp_valid}, 2'b10);
        run(2'b00, 16'h0001, 4'd15, 0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            logic [1:0] op;
            op = 2'($urandom_range(0, 3));
            run(op, 16'($urandom), 4'($urandom_range(0, 15)), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle controller that owns the single combinational `Shifter` and sequences operations through it under a valid/ready request/response handshake. It sits between the EX-stage issue logic and the shifter. SLL and SRA complete in one shifter pass. Rotate-right (ROR), which the shifter cannot do natively, is built from two passes plus merge logic.

## Interface
Parameters:
- `DW`, 16: data width; only 16 is supported.
- `AW`, 4: shift-amount width; equals log2(`DW`).

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer can accept a request.
- `req_op`  in  2  operation: 00 SLL, 01 SRA, 10 ROR, 11 reserved.
- `req_data`  in  `DW`  operand.
- `req_amt`  in  `AW`  shift amount, 0–15.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes the result.
- `rsp_data`  out  `DW`  result.
- `rsp_err`  out  1  the request was reserved or unsupported.
- `busy`  out  1  a request is in flight (state ≠ IDLE).

## Operation
- **States:** IDLE, EXEC1, EXEC2, RESP.
- **Accept:** a request is accepted on a rising edge where `req_valid && req_ready`. At that edge:
  - `req_op`, `req_data` and `req_amt` are captured.
  - `req_ready` drops to 0.
- **IDLE →**
  - EXEC1 for valid ops.
  - RESP for op 11, with `rsp_err=1` and `rsp_data=0`. The shifter is not used.
- **EXEC1:** the shifter is driven from the captured registers.
  - SLL: Mode=0, `Shift_Val`=amt.
  - SRA: Mode=1, `Shift_Val`=amt.
  - ROR: Mode=1, `Shift_In`={1'b0, x[14:0]}, `Shift_Val`=n.
  - The result is registered into the accumulator.
- **EXEC1 →**
  - RESP for SLL/SRA.
  - RESP for ROR with n=0; the result is x unchanged.
  - EXEC2 for ROR with n≠0.
- **EXEC2 (ROR only):**
  - The shifter runs Mode=0 with `Shift_In`=x and `Shift_Val`=(16−n)[3:0].
  - acc ← acc | shifter_out | (x[15] << (15−n)).
  - Next state is RESP.
- **RESP:**
  - `rsp_valid=1`. `rsp_data` and `rsp_err` are held stable until `rsp_ready`.
  - On the handshake edge: state → IDLE, `req_ready` → 1, `rsp_valid` → 0.
- **Shifter inputs outside EXEC1/EXEC2:** forced to 0 (Mode=0, `Shift_In`=0, `Shift_Val`=0).
- **Arithmetic:**
  - All values are 16-bit unsigned, except SRA, which sign-extends from bit 15.
  - (16−n) is computed in 5 bits and truncated to 4.
- **Concurrency:** only one request is in flight. No new request is accepted before the response handshake completes.

## Timing
- **Reset values:** `req_ready=0`, `rsp_valid=0`, `rsp_data=0`, `rsp_err=0`, `busy=0`, state=IDLE, accumulator=0.
- **Ready after reset:** `req_ready` is registered. It rises at the first rising edge with `rst_n` high.
- **Latency** (counted from the accept edge to the first cycle with `rsp_valid` high):
  - SLL, SRA, and ROR with n=0: 2 edges.
  - ROR with n≠0: 3 edges.
  - Reserved op: 1 edge.
- **Backpressure:** RESP holds indefinitely while `rsp_ready=0`, and all outputs are stable.
- **Same-edge pre-assertion:** `rsp_ready` asserted before `rsp_valid` has no effect until RESP.
- **Reset mid-operation:** `rst_n` low in any state immediately forces the reset values. The in-flight request is discarded and no response is issued.
- **Throughput:** at most one request every 3 cycles (SLL/SRA) or every 4 cycles (ROR), with `rsp_ready` tied high.

## Configuration
- **Macro:** `SHIFT_SEQ_ROR_EN`.
- **Defined:** op 10 performs ROR as described above.
- **Undefined:**
  - op 10 is treated exactly like op 11: `rsp_err=1`, `rsp_data=0`, latency 1.
  - EXEC2 and the merge logic are not compiled.

## Structure
- **Package `shift_seq_pkg`:**
  - Op encodings `OP_SLL`, `OP_SRA`, `OP_ROR`, `OP_RSVD`.
  - State enum `seq_state_t`.
  - Constants `DW`, `AW`.
- **Sub-module:** one instance of the existing `Shifter`. Ports: `Shift_Out`, `Shift_In`, `Shift_Val`, `Mode`; Mode 0 is SLL, 1 is SRA.
- No other sub-modules. FSM, operand registers and merge logic live in the top.

## Test plan
- **SRA:** SRA `req_data`=F007, amt=2, `rsp_ready`=1 → `rsp_data`=FC01, `rsp_err`=0, `rsp_valid` 2 edges after accept.
- **SLL:** SLL F007, amt=2 → `rsp_data`=C01C. SRA 0007, amt=6 → 0000.
- **ROR (with `SHIFT_SEQ_ROR_EN`):**
  - 1234 amt=4 → 4123, latency 3.
  - 8001 amt=1 → C000.
  - ABCD amt=0 → ABCD, latency 2.
- **Errors:**
  - op 11, any data → `rsp_err`=1, `rsp_data`=0, latency 1.
  - Without the macro: op 10 with data 1234, amt=4 → same error response.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles after `rsp_valid` →
  - `rsp_data` stable.
  - `req_ready`=0 throughout, with `req_valid`=1 and a second request pending.
  - The second request is accepted only after the handshake.
- **Reset mid-operation:** assert `rst_n`=0 during EXEC2 of a ROR → all outputs 0 at once. After release:
  - `req_ready`=1 after one edge.
  - No stale `rsp_valid`.
  - The next SLL 0001 amt=15 → 8000.
